// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase scheduler.
//   - phase_e   : phase encoding (MG_CR, MY_CR, MR_CG, MR_CY)
//   - LT_*      : lamp patterns, bit order {R,Y,G}
//   - *_DEF     : default parameter values (durations in 1 s ticks)
//   - bin2bcd   : 8-bit binary to 2-digit BCD, saturating at 99
package tl_pkg;

  typedef enum logic [1:0] {
    MG_CR = 2'd0,  // main green, farm red
    MY_CR = 2'd1,  // main yellow, farm red
    MR_CG = 2'd2,  // main red, farm green
    MR_CY = 2'd3   // main red, farm yellow
  } phase_e;

  localparam logic [2:0] LT_R   = 3'b100;
  localparam logic [2:0] LT_Y   = 3'b010;
  localparam logic [2:0] LT_G   = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  localparam int unsigned TICK_DIV_DEF = 50000000;
  localparam int unsigned T_MG_DEF     = 25;
  localparam int unsigned T_Y_DEF      = 5;
  localparam int unsigned T_CG_DEF     = 16;
  localparam int unsigned CNT_W_DEF    = 8;

  function automatic logic [7:0] bin2bcd(input logic [7:0] bin);
    logic [7:0] v;
    logic [7:0] tens;
    logic [7:0] units;
    v     = (bin > 8'd99) ? 8'd99 : bin;
    tens  = v / 8'd10;
    units = v - (tens * 8'd10);
    return {tens[3:0], units[3:0]};
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Prescaler producing the 1 s tick for the phase scheduler.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active-high (legacy name)
//   tick  : one-clk pulse while the prescaler sits at TICK_DIV-1
module tl_tick_gen
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] cnt_q;
  logic [DivW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == DivMax);
    cnt_d = tick ? '0 : cnt_q + DivW'(1);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Main-road / farm-road traffic-light phase scheduler.
// Sequences MG_CR -> MY_CR -> MR_CG -> MR_CY -> MG_CR, each phase lasting T_phase ticks.
// Main green is held at its minimum until a latched farm request exists.
// Optional build macro: FLASH_MODE_EN (maintenance flash on 'maint'); without it
// 'maint' is ignored.
// Ports:
//   clk, rst_n  : clock; asynchronous reset, active-high (legacy name)
//   car_req     : farm-road sensor level, asynchronous
//   maint       : maintenance flash request (FLASH_MODE_EN only)
//   main_lt     : main-road lamps {R,Y,G}
//   farm_lt     : farm-road lamps {R,Y,G}
//   phase       : current phase (0..3)
//   remain      : ticks left in the phase, minus 1
//   remain_bcd  : remain as two BCD digits (8'hAA while flashing)
//   req_pend    : farm request latched, not yet served
//   tick        : 1 s tick pulse
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned T_MG     = T_MG_DEF,
  parameter int unsigned T_Y      = T_Y_DEF,
  parameter int unsigned T_CG     = T_CG_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_req,
  input  logic             maint,
  output logic [2:0]       main_lt,
  output logic [2:0]       farm_lt,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remain,
  output logic [7:0]       remain_bcd,
  output logic             req_pend,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LdMg = CNT_W'(T_MG - 1);
  localparam logic [CNT_W-1:0] LdY  = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] LdCg = CNT_W'(T_CG - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             req_sync1_q, req_sync2_q;
  logic             req_pend_q, req_pend_d;
  logic             enter_cg;

  tl_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

`ifdef FLASH_MODE_EN
  logic maint_sync1_q, maint_sync2_q;
  logic flash_lit_q, flash_lit_d;

  // Lit while idle so every flash episode starts with the lamps on.
  always_comb begin
    flash_lit_d = 1'b1;
    if (maint_sync2_q) begin
      flash_lit_d = tick ? ~flash_lit_q : flash_lit_q;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      maint_sync1_q <= 1'b0;
      maint_sync2_q <= 1'b0;
      flash_lit_q   <= 1'b1;
    end else begin
      maint_sync1_q <= maint;
      maint_sync2_q <= maint_sync1_q;
      flash_lit_q   <= flash_lit_d;
    end
  end
`else
  logic unused_maint;
  assign unused_maint = maint;
`endif

  // Phase sequencing: decrement on each tick, exit on a tick with remain==0.
  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    enter_cg = 1'b0;
    if (tick) begin
      if (remain_q != '0) begin
        remain_d = remain_q - CNT_W'(1);
      end else begin
        case (phase_q)
          MG_CR: begin
            // Otherwise hold at 0: green extends until a request is pending.
            if (req_pend_q) begin
              phase_d  = MY_CR;
              remain_d = LdY;
            end
          end
          MY_CR: begin
            phase_d  = MR_CG;
            remain_d = LdCg;
            enter_cg = 1'b1;
          end
          MR_CG: begin
            phase_d  = MR_CY;
            remain_d = LdY;
          end
          MR_CY: begin
            phase_d  = MG_CR;
            remain_d = LdMg;
          end
          default: begin
            phase_d  = MG_CR;
            remain_d = LdMg;
          end
        endcase
      end
    end
`ifdef FLASH_MODE_EN
    // Frozen while flashing; restart in main green on the edge maint drops.
    if (maint_sync2_q) begin
      enter_cg = 1'b0;
      if (maint_sync1_q) begin
        phase_d  = phase_q;
        remain_d = remain_q;
      end else begin
        phase_d  = MG_CR;
        remain_d = LdMg;
      end
    end
`endif
  end

  // Clear beats set; a still-high sensor re-latches on the following cycle.
  assign req_pend_d = enter_cg ? 1'b0 : (req_pend_q | req_sync2_q);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_q     <= MG_CR;
      remain_q    <= LdMg;
      req_sync1_q <= 1'b0;
      req_sync2_q <= 1'b0;
      req_pend_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      remain_q    <= remain_d;
      req_sync1_q <= car_req;
      req_sync2_q <= req_sync1_q;
      req_pend_q  <= req_pend_d;
    end
  end

  always_comb begin
    main_lt    = LT_G;
    farm_lt    = LT_R;
    remain_bcd = bin2bcd(8'(remain_q));
    case (phase_q)
      MG_CR: begin
        main_lt = LT_G;
        farm_lt = LT_R;
      end
      MY_CR: begin
        main_lt = LT_Y;
        farm_lt = LT_R;
      end
      MR_CG: begin
        main_lt = LT_R;
        farm_lt = LT_G;
      end
      MR_CY: begin
        main_lt = LT_R;
        farm_lt = LT_Y;
      end
      default: begin
        main_lt = LT_G;
        farm_lt = LT_R;
      end
    endcase
`ifdef FLASH_MODE_EN
    if (maint_sync2_q) begin
      main_lt    = flash_lit_q ? LT_Y : LT_OFF;
      farm_lt    = flash_lit_q ? LT_Y : LT_OFF;
      remain_bcd = 8'hAA;  // blank code for the display path
    end
`endif
  end

  assign phase    = phase_q;
  assign remain   = remain_q;
  assign req_pend = req_pend_q;

endmodule

// File: doc/tl_phase_scheduler.md
Name: tl_phase_scheduler

Overview:
- Sequences the main-road/farm-road traffic-light phases from a programmable per-phase duration table.
- Latches farm-road vehicle requests and grants the farm road only after the main road has had its minimum green.
- Exports the remaining phase time in binary and 2-digit BCD, to feed the seven-segment display multiplexer.
- Sits between the vehicle sensor, the lamp drivers and the display path.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick. Minimum 2; benches use 4.
- T_MG, 25: main-green minimum duration, in ticks.
- T_Y, 5: duration of each yellow phase, in ticks.
- T_CG, 16: farm-green duration, in ticks.
- CNT_W, 8: phase counter width. All T_* must be in the range 1..99.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-high. The clock is clk.
- car_req  in  1  farm-road vehicle sensor level; asynchronous to clk.
- maint  in  1  maintenance flash request. Used only with FLASH_MODE_EN.
- main_lt  out  3  main-road lamps, bit order {R,Y,G}.
- farm_lt  out  3  farm-road lamps, bit order {R,Y,G}.
- phase  out  2  current phase: 0=MG_CR, 1=MY_CR, 2=MR_CG, 3=MR_CY.
- remain  out  CNT_W  ticks left in the current phase, minus 1.
- remain_bcd  out  8  remain as BCD: [7:4] tens, [3:0] units.
- req_pend  out  1  a farm request is latched and not yet served.
- tick  out  1  one-clk pulse each time the prescaler wraps.

Behaviour:
- Reset values (asynchronous): phase=MG_CR, main_lt=001, farm_lt=100, remain=T_MG-1, remain_bcd=BCD(T_MG-1), req_pend=0, tick=0, prescaler=0, synchroniser flops=0.
- Prescaler: counts 0..TICK_DIV-1. tick=1 in the cycle the count equals TICK_DIV-1, after which the count wraps to 0.
- car_req path: passes through a 2-flop synchroniser. req_pend sets on the cycle the synchronised level is 1, i.e. 2 clk after the input rises. req_pend clears on the cycle phase enters MR_CG. If set and clear coincide, clear wins; the request re-latches next cycle if the sensor is still high.
- Counter rule, applied in every phase:
  - On entry, remain is loaded with T_phase-1.
  - On each tick with remain>0, remain decrements.
  - On a tick with remain==0, the phase-exit rule applies.
  - A phase therefore lasts exactly T_phase ticks.
- MG_CR (main 001, farm 100): on a tick with remain==0, go to MY_CR if req_pend=1. Otherwise stay in MG_CR with remain held at 0 (green extended indefinitely). A request arriving during the hold exits on the next tick.
- MY_CR (main 010, farm 100): on expiry, go to MR_CG.
- MR_CG (main 100, farm 001): on expiry, go to MR_CY. The farm phase always runs the full T_CG, even if car_req drops.
- MR_CY (main 100, farm 010): on expiry, go to MG_CR.
- Timing of updates: lamp outputs, phase and remain are registered and all change in the same clk as the transition, i.e. the cycle after the tick.
- remain_bcd is combinational from remain (binary-to-BCD, values up to 99).
- Illegal or unreachable encodings recover to MG_CR on the next clk.
- Reset mid-phase: asynchronous return to the reset values. A pending request is lost.

Optional Feature:
- Macro: FLASH_MODE_EN.
- Defined:
  - maint is synchronised with 2 flops.
  - While it is 1: phase and counter are frozen; main_lt and farm_lt both show 010 in one tick period and 000 in the next, toggling on each tick and starting lit.
  - remain_bcd is forced to 8'hAA (blank code for the display path). req_pend is still latched.
  - When maint falls: restart in MG_CR with remain=T_MG-1.
- Undefined: maint is ignored and no flash logic is synthesised.

Decomposition:
- Package tl_pkg holds:
  - the phase encoding constants (MG_CR, MY_CR, MR_CG, MR_CY);
  - the lamp constants LT_R=100, LT_Y=010, LT_G=001, LT_OFF=000;
  - the default durations;
  - a bin2bcd function (8-bit input, 2-digit output, saturating at 99).
- One sub-module: tl_tick_gen, containing the prescaler and producing tick. Everything else stays in tl_phase_scheduler.

Test Plan (TICK_DIV=4, T_MG=3, T_Y=2, T_CG=4):
- Reset, car_req=0 for 40 clk -> phase=0, main_lt=001, farm_lt=100, remain counts 2,1,0 then holds at 0; req_pend=0; tick every 4th clk.
- car_req high from clk 1 -> req_pend=1 at clk 3. Phase sequence is 0 (3 ticks), 1 (2 ticks), 2 (4 ticks), 3 (2 ticks), 0. req_pend=0 on the MR_CG entry cycle. remain_bcd reads 0x03 at MR_CG entry.
- Request raised during the MG_CR hold (remain=0) -> MY_CR is entered one clk after the next tick.
- car_req held high throughout -> after MR_CY the main green still lasts the full 3 ticks before the next MY_CR.
- rst_n pulsed for 1 clk mid-MR_CG -> outputs return asynchronously to the reset values in the same cycle, with req_pend=0.
- FLASH_MODE_EN defined, maint=1 for 6 ticks -> both lamp groups alternate 010/000 each tick, remain_bcd=0xAA. After maint falls: phase=0, remain=2.
